// File: rtl/shift_pkg.sv
// Shared shift-datapath definitions: FSM states, bit order, default width.
// Used by the serial receiver and the uni shift register blocks.
package shift_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic MSB_FIRST = 1'b1;
  localparam logic LSB_FIRST = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/deser_bit_counter.sv
// Bit position counter for the deserializer.
// Clear has priority over increment; term_o flags the last data bit.
module deser_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_deser_rx.sv
// Serial-in/parallel-out receiver with valid/ready on both sides.
// Optional trailing even-parity bit when SHIFT_PARITY_EN is defined.
module shift_deser_rx
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OVR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             msb_first,
  input  logic             abort,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             par_err,
  output logic [OVR_W-1:0] ovr_cnt,
  output logic             busy
);

  state_e           state_q;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q;
  logic             order_q;
  logic             out_valid_q;
  logic [OVR_W-1:0] ovr_q;
  logic             accept, ord, term;
  logic             cnt_clr, cnt_inc, ovr_inc;

  always_comb begin
    sin_ready = (state_q != HOLD) && !abort;
    accept    = sin_valid && sin_ready;
    // First bit of a word uses the live order input
    ord       = (state_q == IDLE) ? msb_first : order_q;
    sr_d      = (ord == MSB_FIRST) ? {sr_q[WIDTH-2:0], sin}
                                   : {sin, sr_q[WIDTH-1:1]};
    cnt_inc   = accept && (state_q == IDLE || state_q == SHIFT);
    cnt_clr   = abort || (accept && state_q == SHIFT && term);
    ovr_inc   = sin_valid && !sin_ready && !abort && (ovr_q != '1);
  end

  deser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .term_o (term)
  );

`ifdef SHIFT_PARITY_EN
  logic par_err_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      dout_q      <= '0;
      order_q     <= MSB_FIRST;
      out_valid_q <= 1'b0;
      ovr_q       <= '0;
`ifdef SHIFT_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      if (ovr_inc) ovr_q <= ovr_q + 1'b1;
      if (abort) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end else begin
        if (cnt_inc) sr_q <= sr_d;
        case (state_q)
          IDLE: begin
            if (accept) begin
              state_q <= SHIFT;
              order_q <= msb_first;
            end
          end
          SHIFT: begin
            if (accept && term) begin
`ifdef SHIFT_PARITY_EN
              state_q     <= PARITY;
`else
              state_q     <= HOLD;
              dout_q      <= sr_d;
              out_valid_q <= 1'b1;
`endif
            end
          end
          PARITY: begin
`ifdef SHIFT_PARITY_EN
            if (accept) begin
              state_q     <= HOLD;
              dout_q      <= sr_q;
              par_err_q   <= ^{sr_q, sin};
              out_valid_q <= 1'b1;
            end
`else
            state_q <= IDLE;
`endif
          end
          HOLD: begin
            if (out_ready) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign ovr_cnt   = ovr_q;
  assign busy      = (state_q != IDLE);
`ifdef SHIFT_PARITY_EN
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deser_rx.sv
// Bench for shift_deser_rx (WIDTH=4, OVR_W=8).
// Scoreboard holds {par_err, dout} per expected word.
module tb_shift_deser_rx;

  localparam int W = 4;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sin = 1'b0;
  logic          sin_valid = 1'b0;
  logic          sin_ready;
  logic          msb_first = 1'b1;
  logic          abort = 1'b0;
  logic [W-1:0]  dout;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          par_err;
  logic [OW-1:0] ovr_cnt;
  logic          busy;

  int total = 0;
  int bad = 0;
  int last_wait = 0;
  int exp_ovr = 0;
  logic [W:0] sb_q[$];

  shift_deser_rx #(.WIDTH(W), .OVR_W(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sin_ready (sin_ready),
    .msb_first (msb_first),
    .abort     (abort),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .par_err   (par_err),
    .ovr_cnt   (ovr_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && !abort && out_valid && out_ready) begin
      logic [W:0] e;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word got=%b want=none", {par_err, dout});
      end else begin
        e = sb_q.pop_front();
        if ({par_err, dout} !== e) begin
          bad++;
          $display("FAIL word got=%b want=%b", {par_err, dout}, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    while (!sin_ready && n < 20) begin
      sin_valid = 1'b0;
      cyc();
      n++;
    end
    last_wait = n;
    if (!sin_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=%b want=1", sin_ready);
    end
    sin = b;
    sin_valid = 1'b1;
    cyc();
  endtask

  task automatic send_par(input logic [W-1:0] w, input logic flip);
`ifdef SHIFT_PARITY_EN
    send_bit((^w) ^ flip);
`else
    if (flip) sin = 1'b0;
    if (w == '0) sin = 1'b0;
`endif
  endtask

  function automatic logic exp_pe(input logic flip);
`ifdef SHIFT_PARITY_EN
    return flip;
`else
    return flip & 1'b0;
`endif
  endfunction

  task automatic send_word(input logic [W-1:0] w, input logic msb,
                           input logic flip, input logic push);
    if (push) sb_q.push_back({exp_pe(flip), w});
    msb_first = msb;
    for (int i = 0; i < W; i++)
      send_bit(msb ? w[W-1-i] : w[i]);
    send_par(w, flip);
    sin_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_idle(input string tag);
    total++;
    if ({out_valid, busy, sin_ready, par_err} !== 4'b0010 || dout !== '0) begin
      bad++;
      $display("FAIL %s got=v%b b%b r%b p%b d%b want=v0 b0 r1 p0 d0000",
               tag, out_valid, busy, sin_ready, par_err, dout);
    end
    total++;
    if (ovr_cnt !== OW'(exp_ovr)) begin
      bad++;
      $display("FAIL %s_ovr got=%0d want=%0d", tag, ovr_cnt, exp_ovr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    exp_ovr = 0;
    check_idle("reset");
  endtask

  task automatic test_msb();
    out_ready = 1'b1;
    send_word(4'b1011, 1'b1, 1'b0, 1'b1);
    total++;
    if ({out_valid, busy} !== 2'b11) begin
      bad++;
      $display("FAIL msb_hold got=%b want=11", {out_valid, busy});
    end
    cyc();
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL msb_release got=%b want=00", {out_valid, busy});
    end
    drain();
  endtask

  task automatic test_lsb();
    out_ready = 1'b1;
    sb_q.push_back({exp_pe(1'b0), 4'b1101});
    msb_first = 1'b0;
    send_bit(1'b1);
    msb_first = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_par(4'b1101, 1'b0);
    sin_valid = 1'b0;
    drain();
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    send_word(4'b0110, 1'b1, 1'b0, 1'b1);
    sin = 1'b1;
    sin_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (sin_ready !== 1'b0 || dout !== 4'b0110) begin
        bad++;
        $display("FAIL hold_stable got=r%b d%b want=r0 d0110", sin_ready, dout);
      end
      cyc();
      exp_ovr++;
    end
    sin_valid = 1'b0;
    total++;
    if (ovr_cnt !== OW'(exp_ovr) || exp_ovr != 5) begin
      bad++;
      $display("FAIL hold_ovr got=%0d want=5", ovr_cnt);
    end
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    msb_first = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    sin_valid = 1'b1;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    sin_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || ovr_cnt !== OW'(exp_ovr)) begin
      bad++;
      $display("FAIL abort_mid got=b%b o%0d want=b0 o%0d", busy, ovr_cnt, exp_ovr);
    end
    send_word(4'b0001, 1'b1, 1'b0, 1'b1);
    drain();
    out_ready = 1'b0;
    send_word(4'b1111, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL abort_hold got=%b want=00", {out_valid, busy});
    end
    out_ready = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic test_parity();
    out_ready = 1'b1;
    send_word(4'b1011, 1'b1, 1'b1, 1'b1);
    drain();
    send_word(4'b0111, 1'b0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_word(4'b1001, 1'b1, 1'b0, 1'b1);
    send_word(4'b0110, 1'b0, 1'b0, 1'b1);
    drain();
    send_word(4'b1100, 1'b1, 1'b0, 1'b1);
    sb_q.push_back({exp_pe(1'b0), 4'b0011});
    msb_first = 1'b1;
    send_bit(1'b0);
    total++;
    if (last_wait != 1) begin
      bad++;
      $display("FAIL b2b_gap got=%0d want=1", last_wait);
    end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_par(4'b0011, 1'b0);
    sin_valid = 1'b0;
    drain();
  endtask

  task automatic test_saturate();
    out_ready = 1'b0;
    send_word(4'b1010, 1'b1, 1'b0, 1'b1);
    sin_valid = 1'b1;
    repeat (300) cyc();
    sin_valid = 1'b0;
    exp_ovr = 255;
    total++;
    if (ovr_cnt !== OW'(exp_ovr)) begin
      bad++;
      $display("FAIL saturate got=%0d want=255", ovr_cnt);
    end
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    msb_first = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    sin_valid = 1'b0;
    rst = 1'b0;
    cyc();
    exp_ovr = 0;
    check_idle("reset_mid");
    rst = 1'b1;
    send_word(4'b1001, 1'b1, 1'b0, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_msb();
    test_lsb();
    test_hold();
    test_abort();
    test_parity();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    repeat (3) cyc();
    total++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL final got=q%0d v%b want=q0 v0", sb_q.size(), out_valid);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
